ysyx_22050710_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_22050710_mem_arbiter
// PURPOSE
//  Shares one memory port between the instruction fetch path (IF) and the load/store path (LS).
//  Sits between the IFU/data-memory users and the single memory interface of the multi-cycle core.
//  Arbitrates requests, sequences each transaction (request phase, then response phase) and
//  routes the response back to its owner. Exactly one transaction is outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH  64  width of all address buses
//  DATA_WIDTH  64  width of data buses; the write mask is DATA_WIDTH/8 bits
// PORTS
//  i_clk        in   1     clock; all state changes on the rising edge
//  i_rst_n      in   1     asynchronous, active-low reset
//  i_if_valid   in   1     IF read request
//  i_if_addr    in   AW    IF read address
//  o_if_ready   out  1     IF request accepted this cycle
//  o_if_rvalid  out  1     IF read data valid; 1-cycle pulse
//  o_if_rdata   out  DW    IF read data
//  i_ls_valid   in   1     LS request
//  i_ls_wen     in   1     LS request is a write (1) or a read (0)
//  i_ls_addr    in   AW    LS address
//  i_ls_wdata   in   DW    LS write data
//  i_ls_wmask   in   DW/8  LS byte write mask
//  o_ls_ready   out  1     LS request accepted this cycle
//  o_ls_rvalid  out  1     LS response (read data, or write ack); 1-cycle pulse
//  o_ls_rdata   out  DW    LS read data; 0 for writes
//  o_mem_valid  out  1     memory request valid
//  o_mem_wen/o_mem_addr/o_mem_wdata/o_mem_wmask  out  1/AW/DW/DW8  registered request fields
//  i_mem_ready  in   1     memory accepts the request
//  i_mem_rvalid in   1     memory response valid (reads and writes)
//  i_mem_rdata  in   DW    memory read data
// BEHAVIOUR
//  FSM: IDLE -> REQ -> RESP -> IDLE. Registers: state, owner (IF/LS), last_owner, request fields.
//  IDLE: grant per the arbitration policy. Winner's o_*_ready=1 combinationally (valid&&ready).
//   Fields latch at the edge: IF forces wen=0, wmask=0, wdata=0. FSM goes to REQ.
//   With no request, stay in IDLE.
//  REQ: o_mem_valid=1 and fields held stable. On i_mem_ready go to RESP.
//   i_mem_rvalid is ignored in REQ.
//  RESP: o_mem_valid=0. On i_mem_rvalid: owner's o_*_rvalid=1 and o_*_rdata=i_mem_rdata
//   (combinational; LS write gives rdata 0). Set last_owner=owner and go to IDLE.
//  o_*_ready is 0 outside IDLE. A new grant is possible in the cycle after the response.
//  Minimum latency, with ready and rvalid both tied high: accept at cycle N, mem valid at N+1,
//   rvalid pulse at N+2. A back-to-back grant needs 3 cycles per transaction.
//  i_mem_rvalid in IDLE is dropped silently. A requester must hold valid and fields stable until ready.
//  Reset (async, any state): state=IDLE, owner=IF, last_owner=LS. All outputs are 0,
//   including o_mem_valid and the registered fields. An in-flight transaction is abandoned,
//   and the memory must be reset in the same event.
//  Both requesters idle with i_mem_* toggling: no outputs change.
// CONFIGURATION
//  YSYX_22050710_ARB_RR_EN defined: round-robin. On a simultaneous request the winner is the
//   requester that is not last_owner (IF wins the first tie after reset). A single request
//   always wins.
//  Undefined: fixed priority; LS always beats IF. last_owner is still kept but has no effect.
// TESTING
//  1 IF alone, addr=0x80000000, ready/rvalid tied 1, rdata=0x00000013 -> if_ready@N,
//    mem_valid@N+1 with addr 0x80000000 and wen=0, if_rvalid@N+2 with rdata 0x13.
//  2 LS write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F; ready delayed 3 cycles
//    -> mem fields stable across all REQ cycles; ls_rvalid once, rdata=0.
//  3 IF and LS both valid in the same cycle, twice -> fixed: LS, LS; RR_EN: IF, then LS.
//  4 i_mem_rvalid=1 during REQ, and a stray pulse in IDLE -> no o_*_rvalid pulse, no state change.
//  5 i_rst_n low during RESP -> all outputs 0 immediately; after release, a new IF request
//    is granted normally.
//  6 IF valid held for 10 transactions, ready random, rvalid delay 0-4 -> exactly 10 responses,
//    in order, each carrying the data for its own address.

Source files
------------

// File: rtl/ysyx_22050710_mem_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and load/store (LS), one transaction at a time.
// Define YSYX_22050710_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module ysyx_22050710_mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_if_valid,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_ready,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                    i_ls_valid,
  input  logic                    i_ls_wen,
  input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
  input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ls_wmask,
  output logic                    o_ls_ready,
  output logic                    o_ls_rvalid,
  output logic [DATA_WIDTH-1:0]   o_ls_rdata,
  output logic                    o_mem_valid,
  output logic                    o_mem_wen,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  state_e                  state_q;
  owner_e                  owner_q;
  owner_e                  last_owner_q;
  logic                    mem_valid_q;
  logic                    mem_wen_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH/8-1:0] mem_wmask_q;

  logic ls_pref;
  logic idle;
  logic grant_ls;
  logic grant_if;
  logic resp_fire;

`ifdef YSYX_22050710_ARB_RR_EN
  assign ls_pref = (last_owner_q == OWN_IF);
`else
  // Fixed priority: last_owner_q is still tracked but never steers the grant.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_q;
  assign ls_pref = 1'b1;
`endif

  // Gating with i_rst_n keeps every output low while reset is asserted.
  assign idle      = i_rst_n && (state_q == IDLE);
  assign grant_ls  = idle && i_ls_valid && (!i_if_valid || ls_pref);
  assign grant_if  = idle && i_if_valid && !grant_ls;
  assign resp_fire = i_rst_n && (state_q == RESP) && i_mem_rvalid;

  assign o_if_ready  = grant_if;
  assign o_ls_ready  = grant_ls;
  assign o_if_rvalid = resp_fire && (owner_q == OWN_IF);
  assign o_ls_rvalid = resp_fire && (owner_q == OWN_LS);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata  = (o_ls_rvalid && !mem_wen_q) ? i_mem_rdata : '0;

  assign o_mem_valid = mem_valid_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wmask = mem_wmask_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            state_q     <= REQ;
            owner_q     <= OWN_LS;
            mem_valid_q <= 1'b1;
            mem_wen_q   <= i_ls_wen;
            mem_addr_q  <= i_ls_addr;
            mem_wdata_q <= i_ls_wdata;
            mem_wmask_q <= i_ls_wmask;
          end else if (grant_if) begin
            state_q     <= REQ;
            owner_q     <= OWN_IF;
            mem_valid_q <= 1'b1;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= i_if_addr;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
          end
        end
        REQ: begin
          // A response strobe arriving before the request is accepted is ignored.
          if (i_mem_ready) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            state_q      <= IDLE;
            last_owner_q <= owner_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Bench for ysyx_22050710_mem_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_ysyx_22050710_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          if_valid = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          ls_valid = 1'b0;
  logic          ls_wen = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [MW-1:0] ls_wmask = '0;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  logic          o_if_ready, o_if_rvalid, o_ls_ready, o_ls_rvalid;
  logic [DW-1:0] o_if_rdata, o_ls_rdata, o_mem_wdata;
  logic          o_mem_valid, o_mem_wen;
  logic [AW-1:0] o_mem_addr;
  logic [MW-1:0] o_mem_wmask;

  ysyx_22050710_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_valid(if_valid), .i_if_addr(if_addr), .o_if_ready(o_if_ready),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_valid(ls_valid), .i_ls_wen(ls_wen), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .i_ls_wmask(ls_wmask), .o_ls_ready(o_ls_ready),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] memfn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {a[31:0] ^ 32'hA5A5_A5A5, a[31:0]};
  endfunction

  // Reference model: a single pending transaction record plus the last-latched request fields.
  typedef struct {
    bit            ls;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } txn_t;

  txn_t pend[$];
  txn_t fld;
  bit   m_issued;
  bit   m_last_ls;

  function automatic bit ls_wins();
`ifdef YSYX_22050710_ARB_RR_EN
    return ls_valid && (!if_valid || !m_last_ls);
`else
    return ls_valid;
`endif
  endfunction

  task automatic m_reset();
    pend.delete();
    fld.ls = 1'b0; fld.wen = 1'b0; fld.addr = '0; fld.wdata = '0; fld.wmask = '0;
    m_issued = 1'b0;
    m_last_ls = 1'b1;
  endtask

  task automatic m_step();
    txn_t t;
    if (pend.size() == 0) begin
      if (ls_wins()) begin
        t.ls = 1'b1; t.wen = ls_wen; t.addr = ls_addr; t.wdata = ls_wdata; t.wmask = ls_wmask;
        pend.push_back(t); fld = t; m_issued = 1'b0;
      end else if (if_valid) begin
        t.ls = 1'b0; t.wen = 1'b0; t.addr = if_addr; t.wdata = '0; t.wmask = '0;
        pend.push_back(t); fld = t; m_issued = 1'b0;
      end
    end else if (!m_issued) begin
      if (mem_ready) m_issued = 1'b1;
    end else if (mem_rvalid) begin
      m_last_ls = pend[0].ls;
      void'(pend.pop_front());
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Event logs built from observed DUT outputs for the directed checks.
  bit            grants[$];
  int            g_cyc = 0;
  bit            r_ls[$];
  logic [DW-1:0] r_data[$];
  int            r_cyc[$];
  bit            mv_prev = 1'b0;
  int            mv_rise_cyc = 0;
  int            mv_cycles = 0;
  logic [AW-1:0] mv_addr = '0;
  logic [DW-1:0] mv_wdata = '0;
  logic [MW-1:0] mv_wmask = '0;
  logic          mv_wen = 1'b0;

  initial begin
    bit            busy, resp, e_ifr, e_lsr, e_ifv, e_lsv;
    logic [DW-1:0] e_ifd, e_lsd;
    forever begin
      @(negedge clk);
      busy  = rst_n && (pend.size() != 0);
      resp  = busy && m_issued && mem_rvalid;
      e_lsr = rst_n && !busy && ls_wins();
      e_ifr = rst_n && !busy && if_valid && !e_lsr;
      e_ifv = resp && !pend[0].ls;
      e_lsv = resp && pend[0].ls;
      e_ifd = e_ifv ? mem_rdata : '0;
      e_lsd = (e_lsv && !pend[0].wen) ? mem_rdata : '0;
      chk("ready", {62'b0, o_if_ready, o_ls_ready}, {62'b0, e_ifr, e_lsr});
      chk("rvalid", {62'b0, o_if_rvalid, o_ls_rvalid}, {62'b0, e_ifv, e_lsv});
      chk("if_rdata", o_if_rdata, e_ifd);
      chk("ls_rdata", o_ls_rdata, e_lsd);
      chk("mem_valid", {63'b0, o_mem_valid}, {63'b0, busy && !m_issued});
      chk("mem_wen", {63'b0, o_mem_wen}, {63'b0, fld.wen});
      chk("mem_addr", o_mem_addr, fld.addr);
      chk("mem_wdata", o_mem_wdata, fld.wdata);
      chk("mem_wmask", {56'b0, o_mem_wmask}, {56'b0, fld.wmask});

      if (o_if_ready) begin grants.push_back(1'b0); g_cyc = cyc; end
      if (o_ls_ready) begin grants.push_back(1'b1); g_cyc = cyc; end
      if (o_mem_valid) begin
        mv_cycles++;
        if (!mv_prev) begin
          mv_rise_cyc = cyc; mv_addr = o_mem_addr; mv_wdata = o_mem_wdata;
          mv_wmask = o_mem_wmask; mv_wen = o_mem_wen;
        end
      end
      mv_prev = o_mem_valid;
      if (o_if_rvalid) begin r_ls.push_back(1'b0); r_data.push_back(o_if_rdata); r_cyc.push_back(cyc); end
      if (o_ls_rvalid) begin r_ls.push_back(1'b1); r_data.push_back(o_ls_rdata); r_cyc.push_back(cyc); end
    end
  end

  // Memory responder: 0 = ready/rvalid tied high, 1 = scripted/random timing, 2 = manual values.
  int            rmode = 0;
  bit            rdy_rand = 1'b0;
  int            rdy_dly = 0;
  int            rv_max = 0;
  logic          man_ready = 1'b0;
  logic          man_rvalid = 1'b0;
  logic [DW-1:0] man_rdata = '0;

  initial begin
    bit            hs;
    bit            waiting;
    int            cnt;
    int            mvcnt;
    logic [AW-1:0] a_l;
    waiting = 1'b0; cnt = 0; mvcnt = 0; a_l = '0;
    forever begin
      @(negedge clk);
      hs = o_mem_valid && mem_ready;
      if (hs) a_l = o_mem_addr;
      mvcnt = o_mem_valid ? mvcnt + 1 : 0;
      @(posedge clk);
      #1;
      if (!rst_n) begin waiting = 1'b0; hs = 1'b0; mvcnt = 0; end
      case (rmode)
        0: begin
          mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = memfn(o_mem_addr);
        end
        1: begin
          if (hs) begin waiting = 1'b1; cnt = $urandom_range(0, rv_max); end
          mem_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : (o_mem_valid && mvcnt >= rdy_dly);
          if (waiting && cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = memfn(a_l); waiting = 1'b0;
          end else begin
            mem_rvalid = 1'b0;
            if (waiting) cnt--;
          end
        end
        default: begin
          mem_ready = man_ready; mem_rvalid = man_rvalid; mem_rdata = man_rdata;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int target);
    int b = 0;
    while (grants.size() < target && b < 100) begin step(); b++; end
    chk("grant_within_budget", {63'b0, grants.size() >= target}, 64'd1);
  endtask

  task automatic wait_resp(input int target);
    int b = 0;
    while (r_data.size() < target && b < 200) begin step(); b++; end
    chk("resp_within_budget", {63'b0, r_data.size() >= target}, 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_handshake"}, {60'b0, o_if_ready, o_ls_ready, o_if_rvalid, o_ls_rvalid}, 64'd0);
    chk({tag, "_mem_valid_wen"}, {62'b0, o_mem_valid, o_mem_wen}, 64'd0);
    chk({tag, "_mem_addr"}, o_mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, {56'b0, o_mem_wmask}, 64'd0);
    chk({tag, "_rdata"}, o_if_rdata | o_ls_rdata, 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, rb;
    logic [AW-1:0] a6[10];

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // 1: IF alone, memory tied ready
    rmode = 0;
    gb = grants.size(); rb = r_data.size();
    if_addr = 64'h8000_0000; if_valid = 1'b1;
    wait_grant(gb + 1);
    if_valid = 1'b0;
    wait_resp(rb + 1);
    step();
    chk("t1_owner", {63'b0, grants[gb]}, 64'd0);
    chk("t1_mem_valid_latency", mv_rise_cyc - g_cyc, 64'd1);
    chk("t1_rvalid_latency", r_cyc[rb] - g_cyc, 64'd2);
    chk("t1_rdata", r_data[rb], 64'h13);
    chk("t1_mem_addr", mv_addr, 64'h8000_0000);
    chk("t1_mem_wen", {63'b0, mv_wen}, 64'd0);

    // 2: LS write, memory ready after three wait cycles
    rmode = 1; rdy_rand = 1'b0; rdy_dly = 3; rv_max = 0;
    step();
    mv_cycles = 0;
    gb = grants.size(); rb = r_data.size();
    ls_wen = 1'b1; ls_addr = 64'h8000_1000; ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    ls_valid = 1'b1;
    wait_grant(gb + 1);
    ls_valid = 1'b0;
    wait_resp(rb + 1);
    repeat (3) step();
    chk("t2_owner", {63'b0, grants[gb]}, 64'd1);
    chk("t2_req_cycles", mv_cycles, 64'd4);
    chk("t2_mem_addr", mv_addr, 64'h8000_1000);
    chk("t2_mem_wdata", mv_wdata, 64'hDEAD_BEEF);
    chk("t2_mem_wmask", {56'b0, mv_wmask}, 64'h0F);
    chk("t2_mem_wen", {63'b0, mv_wen}, 64'd1);
    chk("t2_resp_count", r_data.size() - rb, 64'd1);
    chk("t2_resp_owner", {63'b0, r_ls[rb]}, 64'd1);
    chk("t2_write_rdata", r_data[rb], 64'd0);

    // 3: simultaneous IF and LS requests, held across two grants
    pulse_reset();
    rmode = 0;
    step();
    gb = grants.size(); rb = r_data.size();
    ls_wen = 1'b0; ls_addr = 64'h8000_2000; if_addr = 64'h8000_0200;
    ls_valid = 1'b1; if_valid = 1'b1;
    wait_grant(gb + 2);
    ls_valid = 1'b0; if_valid = 1'b0;
    wait_resp(rb + 2);
    repeat (2) step();
`ifdef YSYX_22050710_ARB_RR_EN
    chk("t3_tie1_winner", {63'b0, grants[gb]}, 64'd0);
    chk("t3_tie2_winner", {63'b0, grants[gb+1]}, 64'd1);
`else
    chk("t3_tie1_winner", {63'b0, grants[gb]}, 64'd1);
    chk("t3_tie2_winner", {63'b0, grants[gb+1]}, 64'd1);
`endif
    chk("t3_resp_order", {62'b0, r_ls[rb], r_ls[rb+1]}, {62'b0, grants[gb], grants[gb+1]});

    // 4: rvalid during the request phase, then stray strobes while idle
    rmode = 2; man_ready = 1'b0; man_rvalid = 1'b0;
    step();
    gb = grants.size(); rb = r_data.size();
    if_addr = 64'h8000_0100; if_valid = 1'b1;
    wait_grant(gb + 1);
    if_valid = 1'b0;
    man_rvalid = 1'b1; man_rdata = 64'h1111;
    repeat (4) step();
    chk("t4_req_holds", {63'b0, o_mem_valid}, 64'd1);
    chk("t4_no_resp_in_req", r_data.size() - rb, 64'd0);
    man_rvalid = 1'b0; man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    repeat (3) step();
    chk("t4_resp_phase_mem_valid", {63'b0, o_mem_valid}, 64'd0);
    chk("t4_no_resp_yet", r_data.size() - rb, 64'd0);
    man_rvalid = 1'b1; man_rdata = 64'hCAFE_F00D;
    step();
    man_rvalid = 1'b0;
    repeat (2) step();
    chk("t4_one_resp", r_data.size() - rb, 64'd1);
    chk("t4_rdata", r_data[rb], 64'hCAFE_F00D);
    gb = grants.size(); rb = r_data.size(); mv_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      man_rvalid = i[0]; man_ready = i[1]; man_rdata = {$urandom, $urandom};
      step();
    end
    man_rvalid = 1'b0; man_ready = 1'b0;
    repeat (2) step();
    chk("t4_stray_resp", r_data.size() - rb, 64'd0);
    chk("t4_stray_grant", grants.size() - gb, 64'd0);
    chk("t4_idle_mem_valid", mv_cycles, 64'd0);

    // 5: reset asserted while waiting for a response
    man_ready = 1'b1; man_rvalid = 1'b0;
    step();
    gb = grants.size(); rb = r_data.size();
    if_addr = 64'h8000_0300; if_valid = 1'b1;
    wait_grant(gb + 1);
    if_valid = 1'b0;
    step();
    chk("t5_in_resp_mem_valid", {63'b0, o_mem_valid}, 64'd0);
    chk("t5_fields_latched", o_mem_addr, 64'h8000_0300);
    rst_n = 1'b0;
    #1;
    chk_zero("t5_async_reset");
    repeat (2) step();
    rst_n = 1'b1; man_ready = 1'b0; rmode = 0;
    step();
    gb = grants.size();
    if_addr = 64'h8000_0000; if_valid = 1'b1;
    wait_grant(gb + 1);
    if_valid = 1'b0;
    wait_resp(rb + 1);
    repeat (2) step();
    chk("t5_post_reset_owner", {63'b0, grants[gb]}, 64'd0);
    chk("t5_only_new_resp", r_data.size() - rb, 64'd1);
    chk("t5_post_reset_rdata", r_data[rb], 64'h13);

    // 6: ten back-to-back IF reads with random memory timing
    rmode = 1; rdy_rand = 1'b1; rv_max = 4;
    step();
    gb = grants.size(); rb = r_data.size();
    if_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a6[k] = 64'h8000_4000 + 64'(k * 8);
      if_addr = a6[k];
      wait_grant(gb + k + 1);
    end
    if_valid = 1'b0;
    wait_resp(rb + 10);
    repeat (8) step();
    chk("t6_resp_count", r_data.size() - rb, 64'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_rdata_%0d", k), r_data[rb+k], memfn(a6[k]));
      chk($sformatf("t6_owner_%0d", k), {63'b0, r_ls[rb+k]}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
